// File: rtl/menu_select.sv
// Menu cursor controller: synchronises raw buttons, moves a cursor with
// press-and-hold auto-repeat, and latches the confirmed item on select.
module menu_select #(
   parameter int N_ITEMS   = 2,
   parameter int WRAP      = 0,
   parameter int RPT_DELAY = 30,
   parameter int RPT_RATE  = 8,
   parameter int IW        = $clog2(N_ITEMS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_sel,
   input  logic          tick,
   input  logic [2:0]    state,
   input  logic [2:0]    menu,
   output logic [IW-1:0] item,
   output logic          moved,
   output logic          sel_valid,
   output logic [IW-1:0] sel_item
);

   localparam logic [IW-1:0] LAST  = IW'(N_ITEMS - 1);
   localparam logic [7:0]    DELAY = 8'(RPT_DELAY);
   localparam logic [7:0]    RATE  = 8'(RPT_RATE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RPT  = 2'd2
   } fsm_t;

   // Button bit order: 0 = up, 1 = down, 2 = select.
   logic [2:0] raw;
   logic [2:0] level;
   logic [2:0] rise;
   logic [1:0] settle_reg;

   assign raw = {btn_sel, btn_down, btn_up};

   // Marks when the synchronisers hold real samples (two clocks after reset),
   // so a button held through reset is not mistaken for released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) settle_reg <= 2'b00;
      else       settle_reg <= {settle_reg[0], 1'b1};
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         logic meta_reg;
         logic sync_reg;
         logic prev_reg;
         logic lock_reg;

         // Two-flop synchroniser, edge-detect history, and a post-reset lock
         // that holds off any action until the button is seen released.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
               prev_reg <= 1'b0;
               lock_reg <= 1'b1;
            end else begin
               meta_reg <= raw[gi];
               sync_reg <= meta_reg;
               prev_reg <= sync_reg;
               lock_reg <= lock_reg & ~(settle_reg[1] & ~sync_reg);
            end
         end

         assign level[gi] = sync_reg;
         assign rise[gi]  = sync_reg & ~prev_reg & ~lock_reg;
      end
   endgenerate

   logic          en;
   logic          up_only;
   logic          dn_only;
   logic          held;
   logic [7:0]    cnt_inc;

   fsm_t          fsm_reg, fsm_next;
   logic          dir_reg, dir_next;      // 1 = down, 0 = up
   logic [7:0]    cnt_reg, cnt_next;
   logic          step_req;
   logic          step_dir;

   logic [IW-1:0] item_reg, item_next, item_stepped;
   logic [IW-1:0] sel_item_reg, sel_item_next;
   logic          moved_reg, moved_next;
   logic          sel_valid_reg, sel_valid_next;
   logic          sel_fire;

   assign en       = (state == menu);
   assign up_only  = level[0] & ~level[1];
   assign dn_only  = level[1] & ~level[0];
   assign held     = dir_reg ? dn_only : up_only;
   assign cnt_inc  = cnt_reg + 8'd1;
   assign sel_fire = en & rise[2];

   // Repeat FSM state, held direction and tick counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_reg <= IDLE;
         dir_reg <= 1'b0;
         cnt_reg <= 8'd0;
      end else begin
         fsm_reg <= fsm_next;
         dir_reg <= dir_next;
         cnt_reg <= cnt_next;
      end
   end

   // Next-state logic: first step on a fresh edge, delayed first repeat, then periodic repeats.
   always_comb begin
      fsm_next = fsm_reg;
      dir_next = dir_reg;
      cnt_next = cnt_reg;
      step_req = 1'b0;
      step_dir = dir_reg;
      if (!en) begin
         fsm_next = IDLE;
         cnt_next = 8'd0;
      end else begin
         case (fsm_reg)
            IDLE: begin
               if (up_only && rise[0]) begin
                  step_req = 1'b1;
                  step_dir = 1'b0;
                  dir_next = 1'b0;
                  cnt_next = 8'd0;
                  fsm_next = HOLD;
               end else if (dn_only && rise[1]) begin
                  step_req = 1'b1;
                  step_dir = 1'b1;
                  dir_next = 1'b1;
                  cnt_next = 8'd0;
                  fsm_next = HOLD;
               end
            end
            HOLD: begin
               if (!held) begin
                  fsm_next = IDLE;
                  cnt_next = 8'd0;
               end else if (tick) begin
                  if (cnt_inc == DELAY) begin
                     step_req = 1'b1;
                     cnt_next = 8'd0;
                     fsm_next = RPT;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
            end
            RPT: begin
               if (!held) begin
                  fsm_next = IDLE;
                  cnt_next = 8'd0;
               end else if (tick) begin
                  if (cnt_inc == RATE) begin
                     step_req = 1'b1;
                     cnt_next = 8'd0;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
            end
            default: begin
               fsm_next = IDLE;
               cnt_next = 8'd0;
            end
         endcase
      end
   end

   // Candidate cursor value after one step, honouring wrap or saturation at the ends.
   always_comb begin
      item_stepped = item_reg;
      if (step_dir) begin
         if (item_reg == LAST) item_stepped = (WRAP != 0) ? '0 : item_reg;
         else                  item_stepped = item_reg + 1'b1;
      end else begin
         if (item_reg == '0)   item_stepped = (WRAP != 0) ? LAST : item_reg;
         else                  item_stepped = item_reg - 1'b1;
      end
   end

   // Cursor/select update: a select in the same clock swallows any step.
   always_comb begin
      item_next      = item_reg;
      sel_item_next  = sel_item_reg;
      moved_next     = 1'b0;
      sel_valid_next = 1'b0;
      if (sel_fire) begin
         sel_valid_next = 1'b1;
         sel_item_next  = item_reg;
      end else if (step_req) begin
         item_next  = item_stepped;
         moved_next = (item_stepped != item_reg);
      end
   end

   // Output registers; item and sel_item persist while the menu is inactive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         item_reg      <= '0;
         sel_item_reg  <= '0;
         moved_reg     <= 1'b0;
         sel_valid_reg <= 1'b0;
      end else begin
         item_reg      <= item_next;
         sel_item_reg  <= sel_item_next;
         moved_reg     <= moved_next;
         sel_valid_reg <= sel_valid_next;
      end
   end

   assign item      = item_reg;
   assign sel_item  = sel_item_reg;
   assign moved     = moved_reg;
   assign sel_valid = sel_valid_reg;

endmodule

// File: tb/tb_menu_select.sv
// Bench for menu_select: three configurations share one stimulus stream and
// are checked every clock against a behavioural model, plus literal pins.
module tb_menu_select;

   localparam int NI [3] = '{4, 4, 16};
   localparam int WR [3] = '{0, 1, 0};
   localparam int DL [3] = '{4, 4, 3};
   localparam int RT [3] = '{3, 3, 2};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0, tick = 1'b0;
   logic [2:0] game_state = 3'd5;
   logic [2:0] menu = 3'd5;

   logic [1:0] item_a, sel_item_a, item_b, sel_item_b;
   logic [3:0] item_c, sel_item_c;
   logic       moved_a, moved_b, moved_c, selv_a, selv_b, selv_c;

   menu_select #(.N_ITEMS(4), .WRAP(0), .RPT_DELAY(4), .RPT_RATE(3)) dut_a (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
      .tick(tick), .state(game_state), .menu(menu), .item(item_a), .moved(moved_a),
      .sel_valid(selv_a), .sel_item(sel_item_a));

   menu_select #(.N_ITEMS(4), .WRAP(1), .RPT_DELAY(4), .RPT_RATE(3)) dut_b (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
      .tick(tick), .state(game_state), .menu(menu), .item(item_b), .moved(moved_b),
      .sel_valid(selv_b), .sel_item(sel_item_b));

   menu_select #(.N_ITEMS(16), .WRAP(0), .RPT_DELAY(3), .RPT_RATE(2)) dut_c (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
      .tick(tick), .state(game_state), .menu(menu), .item(item_c), .moved(moved_c),
      .sel_valid(selv_c), .sel_item(sel_item_c));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   bit hist [3][3];
   bit blk [3];
   int edges;
   int m_item [3], m_sel_item [3], m_hold [3], m_ticks [3];
   bit m_moved [3], m_sel_valid [3];
   int moved_cnt [3], selv_cnt [3];

   function automatic int act_item(int k);
      case (k)
         0: return int'(item_a);
         1: return int'(item_b);
         default: return int'(item_c);
      endcase
   endfunction

   function automatic int act_sel_item(int k);
      case (k)
         0: return int'(sel_item_a);
         1: return int'(sel_item_b);
         default: return int'(sel_item_c);
      endcase
   endfunction

   function automatic int act_moved(int k);
      case (k)
         0: return int'(moved_a);
         1: return int'(moved_b);
         default: return int'(moved_c);
      endcase
   endfunction

   function automatic int act_selv(int k);
      case (k)
         0: return int'(selv_a);
         1: return int'(selv_b);
         default: return int'(selv_c);
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      edges = 0;
      for (int b = 0; b < 3; b++) begin
         blk[b] = 1'b1;
         for (int d = 0; d < 3; d++) hist[b][d] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         m_item[k] = 0; m_sel_item[k] = 0; m_hold[k] = 0; m_ticks[k] = 0;
         m_moved[k] = 1'b0; m_sel_valid[k] = 1'b0;
      end
   endtask

   // One clock of behaviour: button samples reach the logic two clocks late,
   // a press acts once on its edge, then after DL ticks and every RT ticks.
   task automatic model_edge();
      bit raw [3];
      bit s [3];
      bit p [3];
      bit r [3];
      bit en;
      int dir_now, step, nxt;
      raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_sel;
      edges++;
      for (int b = 0; b < 3; b++) begin
         s[b] = hist[b][1];
         p[b] = hist[b][2];
         r[b] = s[b] && !p[b] && !blk[b];
         if (edges >= 3 && !s[b]) blk[b] = 1'b0;
         hist[b][2] = hist[b][1];
         hist[b][1] = hist[b][0];
         hist[b][0] = raw[b];
      end
      en = (game_state == menu);
      dir_now = (s[0] && !s[1]) ? -1 : ((s[1] && !s[0]) ? 1 : 0);
      for (int k = 0; k < 3; k++) begin
         step = 0;
         if (!en) begin
            m_hold[k] = 0;
         end else if (m_hold[k] != 0) begin
            if (dir_now != m_hold[k]) m_hold[k] = 0;
            else if (tick) begin
               m_ticks[k]++;
               if (m_ticks[k] == DL[k] ||
                   (m_ticks[k] > DL[k] && (m_ticks[k] - DL[k]) % RT[k] == 0))
                  step = m_hold[k];
            end
         end else if (dir_now == -1 && r[0]) begin
            step = -1; m_hold[k] = -1; m_ticks[k] = 0;
         end else if (dir_now == 1 && r[1]) begin
            step = 1; m_hold[k] = 1; m_ticks[k] = 0;
         end
         m_moved[k] = 1'b0;
         m_sel_valid[k] = 1'b0;
         if (en && r[2]) begin
            m_sel_valid[k] = 1'b1;
            m_sel_item[k] = m_item[k];
         end else if (step != 0) begin
            nxt = m_item[k] + step;
            if (nxt < 0) nxt = (WR[k] != 0) ? NI[k] - 1 : 0;
            if (nxt >= NI[k]) nxt = (WR[k] != 0) ? 0 : NI[k] - 1;
            m_moved[k] = (nxt != m_item[k]);
            m_item[k] = nxt;
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("item[%0d]", k), act_item(k), m_item[k]);
         chk($sformatf("moved[%0d]", k), act_moved(k), int'(m_moved[k]));
         chk($sformatf("sel_valid[%0d]", k), act_selv(k), int'(m_sel_valid[k]));
         chk($sformatf("sel_item[%0d]", k), act_sel_item(k), m_sel_item[k]);
         if (act_moved(k) == 1) moved_cnt[k]++;
         if (act_selv(k) == 1) selv_cnt[k]++;
      end
   endtask

   task automatic run_cycle();
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge();
      #1;
      compare_all();
   endtask

   task automatic lit_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s item[%0d]", tag, k), act_item(k), 0);
         chk($sformatf("%s sel_item[%0d]", tag, k), act_sel_item(k), 0);
         chk($sformatf("%s moved[%0d]", tag, k), act_moved(k), 0);
         chk($sformatf("%s sel_valid[%0d]", tag, k), act_selv(k), 0);
      end
   endtask

   // Async reset raised between clock edges; outputs must clear at once.
   task automatic pulse_reset(input int n);
      #2;
      reset = 1'b1;
      #1;
      lit_zero("async_rst");
      model_reset();
      compare_all();
      repeat (n) run_cycle();
      reset = 1'b0;
   endtask

   task automatic press(input bit u, input bit d, input bit s, input int hold);
      btn_up = u; btn_down = d; btn_sel = s;
      repeat (hold) run_cycle();
      btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
      repeat (4) run_cycle();
   endtask

   task automatic clear_counts();
      for (int k = 0; k < 3; k++) begin
         moved_cnt[k] = 0;
         selv_cnt[k] = 0;
      end
   endtask

   initial begin
      int exp_a [4];
      exp_a = '{1, 2, 3, 3};
      model_reset();
      clear_counts();
      repeat (3) run_cycle();
      lit_zero("reset");
      reset = 1'b0;
      repeat (4) run_cycle();

      // Up at item 0: saturating copy stays, wrapping copy goes to the end.
      clear_counts();
      press(1, 0, 0, 4);
      chk("sat_up item_a", act_item(0), 0);
      chk("sat_up moved_a count", moved_cnt[0], 0);
      chk("wrap_up item_b", act_item(1), 3);

      // Four downs on the saturating 4-entry menu.
      for (int i = 0; i < 4; i++) begin
         press(0, 1, 0, 4);
         chk($sformatf("down%0d item_a", i), act_item(0), exp_a[i]);
      end
      chk("down x4 item_c", act_item(2), 4);

      // Wrapping copy at 3: down wraps to 0 with a single moved pulse, up returns.
      clear_counts();
      press(0, 1, 0, 4);
      chk("wrap_down item_b", act_item(1), 0);
      chk("wrap_down moved_b count", moved_cnt[1], 1);
      press(1, 0, 0, 4);
      chk("wrap_up2 item_b", act_item(1), 3);
      chk("up item_a", act_item(0), 2);

      // Select and down together: select wins, held select fires once.
      clear_counts();
      press(0, 1, 1, 6);
      chk("sel_down item_a", act_item(0), 2);
      chk("sel_down sel_item_a", act_sel_item(0), 2);
      chk("sel_down sel_valid count", selv_cnt[0], 1);
      chk("sel_down moved count", moved_cnt[0], 0);

      // Button held while menu inactive does nothing on menu entry.
      game_state = 3'd1;
      btn_down = 1'b1;
      repeat (6) run_cycle();
      game_state = 3'd5;
      for (int i = 0; i < 10; i++) begin
         tick = (i % 2 == 1);
         run_cycle();
      end
      tick = 1'b0;
      chk("held_on_entry item_a", act_item(0), 2);
      btn_down = 1'b0;
      repeat (4) run_cycle();
      press(0, 1, 0, 4);
      chk("repress item_a", act_item(0), 3);
      chk("repress item_b", act_item(1), 0);

      // Auto-repeat: 16 entries, delay 3, rate 2, nine ticks -> five steps.
      pulse_reset(2);
      repeat (4) run_cycle();
      btn_down = 1'b1;
      repeat (4) run_cycle();
      for (int i = 0; i < 9; i++) begin
         tick = 1'b1;
         run_cycle();
         tick = 1'b0;
         repeat (2) run_cycle();
      end
      chk("repeat item_c", act_item(2), 5);
      chk("repeat item_a", act_item(0), 3);
      chk("repeat item_b", act_item(1), 3);
      repeat (2) run_cycle();

      // Reset during repeat with the button still held: nothing moves afterwards.
      pulse_reset(3);
      for (int i = 0; i < 20; i++) begin
         tick = (i % 2 == 0);
         run_cycle();
      end
      tick = 1'b0;
      chk("held_thru_reset item_c", act_item(2), 0);
      chk("held_thru_reset item_a", act_item(0), 0);
      btn_down = 1'b0;
      repeat (4) run_cycle();
      press(0, 1, 0, 4);
      chk("after_reset press item_a", act_item(0), 1);

      // Randomised traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(15) == 0) btn_up = ~btn_up;
         if ($urandom_range(15) == 0) btn_down = ~btn_down;
         if ($urandom_range(19) == 0) btn_sel = ~btn_sel;
         tick = ($urandom_range(2) == 0);
         if ($urandom_range(59) == 0)
            game_state = ($urandom_range(3) != 0) ? 3'd5 : 3'($urandom_range(7));
         if ($urandom_range(799) == 0) pulse_reset(2);
         run_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/menu_select.md
MENU_SELECT -- requirements
Module: menu_select

Interface
REQ-001 SHALL have parameter N_ITEMS, default 2: number of menu entries, legal range 2..16.
REQ-002 SHALL have parameter WRAP, default 0: 1 = cursor wraps at the ends, 0 = cursor saturates.
REQ-003 SHALL have parameter RPT_DELAY, default 30: ticks a button is held before auto-repeat starts, legal range 1..255.
REQ-004 SHALL have parameter RPT_RATE, default 8: ticks between auto-repeat steps, legal range 1..255.
REQ-005 SHALL have parameter IW, default $clog2(N_ITEMS): item index width.
REQ-006 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port btn_up, input, 1 bit: raw up button, asynchronous to clk, active-high.
REQ-009 SHALL have port btn_down, input, 1 bit: raw down button, asynchronous, active-high.
REQ-010 SHALL have port btn_sel, input, 1 bit: raw confirm button, asynchronous, active-high.
REQ-011 SHALL have port tick, input, 1 bit: one-clk frame/animate strobe used as the repeat timebase.
REQ-012 SHALL have port state, input, 3 bits: current game state.
REQ-013 SHALL have port menu, input, 3 bits: state code meaning "menu active".
REQ-014 SHALL have port item, output, IW bits: current cursor index.
REQ-015 SHALL have port moved, output, 1 bit: one-clk pulse on every cursor change.
REQ-016 SHALL have port sel_valid, output, 1 bit: one-clk pulse when a choice is confirmed.
REQ-017 SHALL have port sel_item, output, IW bits: index latched at the last confirm.

Function
REQ-018 SHALL pass each button through a 2-flop synchroniser; all later logic uses only the synchronised signals.
REQ-019 SHALL define the enable en = (state == menu); while en = 0, the repeat FSM SHALL be forced to IDLE, and moved and sel_valid SHALL stay 0.
REQ-020 SHALL treat up-only or down-only as a valid direction; both up and down high at once SHALL count as no direction, and the FSM SHALL go to IDLE.
REQ-021 SHALL implement the FSM states IDLE, HOLD and RPT.
REQ-022 In IDLE, a rising edge of a valid direction with en = 1 SHALL step the cursor once in the same clk, clear the tick counter, and enter HOLD.
REQ-023 HOLD SHALL count ticks while the same direction is held; when the count reaches RPT_DELAY it SHALL step once, clear the counter, and enter RPT.
REQ-024 RPT SHALL step once every RPT_RATE ticks while the same direction is held.
REQ-025 Release, a direction change, or a lost enable in HOLD or RPT SHALL return the FSM to IDLE with no step; a new direction needs a fresh rising edge.
REQ-026 Up SHALL decrement item and down SHALL increment it.
REQ-027 With WRAP = 1, decrementing 0 SHALL give N_ITEMS-1 and incrementing N_ITEMS-1 SHALL give 0.
REQ-028 With WRAP = 0, a step past either end SHALL leave item unchanged, with moved = 0.
REQ-029 moved SHALL assert in the clk after item updates, and only when the value actually changed.
REQ-030 A rising edge of btn_sel with en = 1 SHALL latch sel_item <= item and pulse sel_valid for exactly one clk; holding btn_sel SHALL NOT re-trigger.
REQ-031 If a select edge and a step occur in the same clk, select SHALL win: sel_item gets the pre-step item, and the step SHALL be discarded.
REQ-032 item and sel_item SHALL be retained while en = 0; re-entering the menu SHALL NOT reset them.
REQ-033 The edge-detect registers SHALL update every clk regardless of en, so a button already held on menu entry produces no step.

Reset
REQ-034 Asserting reset SHALL immediately set item = 0, sel_item = 0, moved = 0, sel_valid = 0, FSM = IDLE, counters = 0, and synchroniser and edge flops = 0.
REQ-035 Reset asserted mid-hold SHALL abort the repeat; after release, a held button SHALL NOT act until it is released and pressed again.

Verification
REQ-036 N_ITEMS=4, WRAP=0, item=0: press up -> item stays 0, moved=0; press down 4 times -> item 1,2,3,3.
REQ-037 N_ITEMS=4, WRAP=1, item=3: press down -> item=0 with one moved pulse; press up -> item=3.
REQ-038 RPT_DELAY=3, RPT_RATE=2, N_ITEMS=16, WRAP=0: hold down for 9 ticks -> steps at press, tick 3, tick 5, tick 7, tick 9, giving item=5.
REQ-039 Set item=2, then press sel and down on the same clk -> sel_valid one clk, sel_item=2, item stays 2.
REQ-040 state!=menu, press and hold down, then set state=menu -> no step until release and re-press.
REQ-041 Assert reset during RPT at item=5 -> all outputs 0 immediately; keep down held after release -> item stays 0.
